stepgen_seq: RTL and testbench

Segment sequencer that drives one `stepgen` joint from a small queue of motion segments. Host logic pushes segments (period command plus duration or target position) through a valid/ready handshake. The sequencer plays them back-to-back onto `jointFreqCmd`/`jointEnable`, ending each segment by tick count or by `jointFeedback` reaching a target. It handles pause, abort, underrun and timeout, and sits between the host register interface and the `stepgen` instance.

---
 rtl/stepgen_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_stepgen_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepgen_seq.sv
`timescale 1ns/1ps
// stepgen_seq: queued motion-segment sequencer feeding one stepgen joint.
// A segment ends on a tick count (timed) or on feedback crossing a target (positional).
module stepgen_seq #(
    parameter int DEPTH  = 4,
    parameter int TICK_W = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     abort,
    input  logic                     clrFlags,
    input  logic                     segValid,
    output logic                     segReady,
    input  logic                     segMode,
    input  logic signed [31:0]       segCmd,
    input  logic signed [31:0]       segTarget,
    input  logic        [TICK_W-1:0] segTicks,
    input  logic signed [31:0]       jointFeedback,
    output logic signed [31:0]       jointFreqCmd,
    output logic                     jointEnable,
    output logic                     busy,
    output logic                     segDone,
    output logic                     underrun,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   fifoLevel
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    typedef struct packed {
        logic                     mode;
        logic signed [31:0]       cmd;
        logic signed [31:0]       target;
        logic        [TICK_W-1:0] ticks;
    } seg_t;

    seg_t               r_mem [DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    state_t             r_state;
    state_t             w_state_nxt;
    seg_t               r_cur;
    logic [TICK_W-1:0]  r_cnt;
    logic [TICK_W-1:0]  w_cnt_nxt;
    logic [TICK_W-1:0]  w_cnt_inc;
    logic [TICK_W-1:0]  w_ticks_eff;
    logic signed [31:0] r_cmd;
    logic signed [31:0] w_cmd_nxt;
    logic               r_jen;
    logic               w_jen_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_underrun;
    logic               r_timeout;
    logic               w_set_underrun;
    logic               w_set_timeout;
    logic               w_clr_flags;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_empty;
    logic               w_full;
    logic [AW:0]        w_level;
    seg_t               w_head;
    seg_t               w_seg_in;
    logic               w_pos_done;
    logic               w_seg_done;
    logic               w_seg_timeout;

    assign w_level  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (w_level == '0);
    assign w_full   = (w_level == (AW+1)'(DEPTH));
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_seg_in = '{segMode, segCmd, segTarget, segTicks};

    assign segReady  = !w_full && (r_state != S_HALT) && !abort;
    assign w_push    = segValid && segReady;
    assign fifoLevel = w_level;

    // Completion tests look at the count this cycle will reach, so a segment of
    // N ticks occupies the outputs for exactly N enabled cycles.
    assign w_cnt_inc   = r_cnt + TICK_W'(1);
    assign w_ticks_eff = (r_cur.ticks == '0) ? TICK_W'(1) : r_cur.ticks;

    always_comb begin
        w_pos_done = 1'b0;
        if ($signed(r_cur.cmd) == 0)
            w_pos_done = 1'b1;
        else if ($signed(r_cur.cmd) > 0)
            w_pos_done = (jointFeedback >= r_cur.target);
        else
            w_pos_done = (jointFeedback <= r_cur.target);
    end

    assign w_seg_done    = r_cur.mode ? w_pos_done : (w_cnt_inc >= w_ticks_eff);
    assign w_seg_timeout = r_cur.mode && (r_cur.ticks != '0) && (w_cnt_inc >= r_cur.ticks);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cmd_nxt      = r_cmd;
        w_jen_nxt      = r_jen;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_pop          = 1'b0;
        w_flush        = 1'b0;
        w_set_underrun = 1'b0;
        w_set_timeout  = 1'b0;
        w_clr_flags    = clrFlags;

        if (abort) begin
            w_flush     = 1'b1;
            w_clr_flags = 1'b0;
            w_cmd_nxt   = '0;
            w_jen_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = (r_state == S_HALT) ? S_HALT : S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_cmd_nxt  = '0;
                    w_jen_nxt  = 1'b0;
                    w_busy_nxt = 1'b0;
                    if (enable && !w_empty) begin
                        w_pop       = 1'b1;
                        w_cnt_nxt   = '0;
                        w_cmd_nxt   = w_head.cmd;
                        w_jen_nxt   = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    w_jen_nxt = enable;
                    if (enable) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_seg_done) begin
                            w_done_nxt = 1'b1;
                            if (!w_empty) begin
                                w_pop     = 1'b1;
                                w_cnt_nxt = '0;
                                w_cmd_nxt = w_head.cmd;
                            end else begin
                                w_set_underrun = ($signed(r_cur.cmd) != 0);
                                w_cmd_nxt      = '0;
                                w_jen_nxt      = 1'b0;
                                w_busy_nxt     = 1'b0;
                                w_state_nxt    = S_IDLE;
                            end
                        end else if (w_seg_timeout) begin
                            w_set_timeout = 1'b1;
                            w_flush       = 1'b1;
                            w_cmd_nxt     = '0;
                            w_jen_nxt     = 1'b0;
                            w_busy_nxt    = 1'b0;
                            w_state_nxt   = S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    w_cmd_nxt  = '0;
                    w_jen_nxt  = 1'b0;
                    w_busy_nxt = 1'b0;
                    if (clrFlags)
                        w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cur      <= '0;
            r_cnt      <= '0;
            r_cmd      <= '0;
            r_jen      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here sees pre-edge values.
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cmd      <= w_cmd_nxt;
            r_jen      <= w_jen_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_underrun <= w_set_underrun | (r_underrun & ~w_clr_flags);
            r_timeout  <= w_set_timeout  | (r_timeout  & ~w_clr_flags);
            if (w_pop)
                r_cur <= w_head;
            // A flush also discards any entry being written in the same cycle.
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // NOTE: the segment store is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push && !w_flush)
            r_mem[r_wr_ptr[AW-1:0]] <= w_seg_in;
    end

    assign jointFreqCmd = r_cmd;
    assign jointEnable  = r_jen;
    assign busy         = r_busy;
    assign segDone      = r_done;
    assign underrun     = r_underrun;
    assign timeout      = r_timeout;
endmodule

// File: tb/tb_stepgen_seq.sv
`timescale 1ns/1ps
// tb_stepgen_seq: vector table of single segments, directed multi-cycle sequences,
// and a randomized segment stream checked against a remaining-ticks model.
module tb_stepgen_seq;
    localparam int DEPTH  = 4;
    localparam int TICK_W = 24;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     enable;
    logic                     abort;
    logic                     clrFlags;
    logic                     segValid;
    logic                     segReady;
    logic                     segMode;
    logic signed [31:0]       segCmd;
    logic signed [31:0]       segTarget;
    logic        [TICK_W-1:0] segTicks;
    logic signed [31:0]       jointFeedback;
    logic signed [31:0]       jointFreqCmd;
    logic                     jointEnable;
    logic                     busy;
    logic                     segDone;
    logic                     underrun;
    logic                     timeout;
    logic [LW-1:0]            fifoLevel;

    int n_cmp  = 0;
    int n_fail = 0;

    stepgen_seq #(.DEPTH(DEPTH), .TICK_W(TICK_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .abort        (abort),
        .clrFlags     (clrFlags),
        .segValid     (segValid),
        .segReady     (segReady),
        .segMode      (segMode),
        .segCmd       (segCmd),
        .segTarget    (segTarget),
        .segTicks     (segTicks),
        .jointFeedback(jointFeedback),
        .jointFreqCmd (jointFreqCmd),
        .jointEnable  (jointEnable),
        .busy         (busy),
        .segDone      (segDone),
        .underrun     (underrun),
        .timeout      (timeout),
        .fifoLevel    (fifoLevel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic mode;
        int   cmd;
        int   target;
        int   ticks;
        int   fb;
        int   exp_dur;
        bit   exp_to;
        bit   exp_und;
    } vec_t;

    vec_t vecs [12];

    int          dur, dones, badc, low, exp_c;
    bit          fin;
    int          k_r, s_r, cur_r, rem_r;
    bit          act_m, e_r, done_p, und_m;
    int          q_cmd [DEPTH];
    int          q_ticks [DEPTH];
    logic [31:0] exp_cmd;
    logic        exp_jen;
    logic [38:0] exp_v, act_v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_seg(input logic mode, input int cmd, input int tgt, input int ticks);
        segMode   = mode;
        segCmd    = cmd;
        segTarget = tgt;
        segTicks  = TICK_W'(ticks);
        segValid  = 1'b1;
    endtask

    task automatic push_seg(input logic mode, input int cmd, input int tgt, input int ticks);
        drive_seg(mode, cmd, tgt, ticks);
        step();
        segValid = 1'b0;
    endtask

    task automatic pulse_clr();
        clrFlags = 1'b1;
        step();
        clrFlags = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; abort = 1'b0; clrFlags = 1'b0; segValid = 1'b0;
        segMode = 1'b0; segCmd = 0; segTarget = 0; segTicks = '0; jointFeedback = 0;

        //            mode  cmd   tgt   ticks fb  dur to    und
        vecs[0]  = '{1'b0, 100,   0,   10,  0,  10, 1'b0, 1'b1};
        vecs[1]  = '{1'b0,   7,   0,    0,  0,   1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0,   0,   0,    3,  0,   3, 1'b0, 1'b0};
        vecs[3]  = '{1'b0,  -5,   0,    1,  0,   1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1,  20,   5,    0, 10,   1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1,  -3,  10,    0, 10,   1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1,   0, 100,    0,  0,   1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1,  20,  11,    4, 10,   4, 1'b1, 1'b0};
        vecs[8]  = '{1'b1,  20,  10,    1, 10,   1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, -20,   5,    8, 10,   8, 1'b1, 1'b0};
        vecs[10] = '{1'b1,  20, 1000,  50,  0,  50, 1'b1, 1'b0};
        vecs[11] = '{1'b1,  -7,  -3,    0, -3,   1, 1'b0, 1'b1};

        // Reset state
        step(); step();
        check("rst_cmd", jointFreqCmd, 0);
        check("rst_ctrl", {jointEnable, busy, segDone, underrun, timeout}, 5'b0);
        check("rst_level", fifoLevel, 0);
        check("rst_ready", segReady, 1);
        rst_n = 1'b1;
        step();

        // Write-to-output latency from IDLE with enable high
        enable = 1'b1;
        drive_seg(1'b0, 9, 0, 2);
        step();
        segValid = 1'b0;
        check("lat_busy_k", busy, 0);
        check("lat_level_k", fifoLevel, 1);
        step();
        check("lat_busy_k1", busy, 1);
        check("lat_cmd_k1", jointFreqCmd, 9);
        check("lat_level_k1", fifoLevel, 0);
        step();
        step();
        check("lat_end", {busy, segDone, underrun}, 3'b011);
        enable = 1'b0;
        pulse_clr();

        // Timed back-to-back sequence
        push_seg(1'b0, 100, 0, 10);
        push_seg(1'b0, -50, 0, 5);
        enable = 1'b1;
        badc = 0; dones = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            exp_c = (c < 10) ? 100 : (c < 15) ? -50 : 0;
            if (jointFreqCmd !== exp_c) badc++;
            if (segDone !== (c == 10 || c == 15)) dones++;
        end
        check("timed_cmd_trace_errors", badc, 0);
        check("timed_done_trace_errors", dones, 0);
        check("timed_end", {busy, jointEnable, underrun}, 3'b001);

        // Positional segment, feedback stepping every 40 cycles
        enable = 1'b0;
        pulse_clr();
        jointFeedback = 0;
        push_seg(1'b1, 20, 3, 0);
        enable = 1'b1;
        badc = 0;
        for (int c = 0; c < 120; c++) begin
            step();
            if (busy !== 1'b1 || jointFreqCmd !== 20) badc++;
            if ((c + 1) % 40 == 0) jointFeedback = jointFeedback + 1;
        end
        check("pos_run_errors", badc, 0);
        step();
        check("pos_done", {busy, segDone, jointEnable}, 3'b010);
        check("pos_cmd_zero", jointFreqCmd, 0);
        enable = 1'b0;

        // Single-segment vector table
        for (int i = 0; i < 12; i++) begin
            enable = 1'b0;
            pulse_clr();
            jointFeedback = vecs[i].fb;
            push_seg(vecs[i].mode, vecs[i].cmd, vecs[i].target, vecs[i].ticks);
            enable = 1'b1;
            dur = 0; dones = 0; badc = 0; fin = 1'b0;
            for (int c = 0; c < 200 && !fin; c++) begin
                step();
                if (busy) begin
                    dur++;
                    if (jointFreqCmd !== vecs[i].cmd) badc++;
                end
                if (segDone) dones++;
                if (dur > 0 && !busy) fin = 1'b1;
            end
            enable = 1'b0;
            check($sformatf("vec%0d_dur", i), dur, vecs[i].exp_dur);
            check($sformatf("vec%0d_segdone", i), dones, vecs[i].exp_to ? 0 : 1);
            check($sformatf("vec%0d_flags", i), {underrun, timeout}, {vecs[i].exp_und, vecs[i].exp_to});
            check($sformatf("vec%0d_cmd_errors", i), badc, 0);
            check($sformatf("vec%0d_ready", i), segReady, !vecs[i].exp_to);
            if (vecs[i].exp_to) begin
                drive_seg(1'b0, 1, 0, 1);
                step();
                segValid = 1'b0;
                check($sformatf("vec%0d_halt_push_refused", i), fifoLevel, 0);
                pulse_clr();
                check($sformatf("vec%0d_clr_ready", i), {segReady, timeout, busy}, 3'b100);
            end
        end

        // Full / backpressure
        pulse_clr();
        for (int j = 0; j < 4; j++) push_seg(1'b0, j + 1, 0, 3);
        check("full_level", fifoLevel, 4);
        check("full_ready", segReady, 0);
        drive_seg(1'b0, 5, 0, 3);
        step(); step();
        check("full_held_level", fifoLevel, 4);
        enable = 1'b1;
        step();
        check("full_pop_level", fifoLevel, 3);
        check("full_pop_ready", segReady, 1);
        check("full_first_cmd", jointFreqCmd, 1);
        step();
        segValid = 1'b0;
        check("full_refill_level", fifoLevel, 4);
        badc = 0;
        for (int c = 3; c <= 16; c++) begin
            step();
            exp_c = (c <= 15) ? ((c - 1) / 3 + 1) : 0;
            if (jointFreqCmd !== exp_c || busy !== (c <= 15)) badc++;
        end
        check("full_trace_errors", badc, 0);
        check("full_last_done", segDone, 1);

        // Pause in the middle of a timed segment
        enable = 1'b0;
        push_seg(1'b0, 33, 0, 20);
        enable = 1'b1;
        dur = 0; low = 0; badc = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (busy) begin
                dur++;
                if (!jointEnable) low++;
                if (jointFreqCmd !== 33) badc++;
            end else if (dur > 0) begin
                break;
            end
            enable = !(dur >= 5 && dur < 12);
        end
        check("pause_dur", dur, 27);
        check("pause_jen_low", low, 7);
        check("pause_cmd_errors", badc, 0);

        // Abort with a coincident push, 3 entries queued; underrun left set on purpose
        enable = 1'b0;
        for (int j = 0; j < 4; j++) push_seg(1'b0, 10 + j, 0, 10);
        enable = 1'b1;
        step();
        check("abort_pre_level", fifoLevel, 3);
        step();
        abort = 1'b1;
        drive_seg(1'b0, 99, 0, 10);
        #1;
        check("abort_ready", segReady, 0);
        step();
        abort = 1'b0;
        segValid = 1'b0;
        check("abort_level", fifoLevel, 0);
        check("abort_out", {busy, jointEnable, segDone, jointFreqCmd}, 0);
        check("abort_flags", {underrun, timeout}, 2'b10);
        badc = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (busy || segDone || fifoLevel != 0) badc++;
        end
        check("abort_dropped_errors", badc, 0);

        // Randomized timed segments with random pauses
        for (int r = 0; r < 30; r++) begin
            enable = 1'b0;
            pulse_clr();
            k_r = $urandom_range(DEPTH, 1);
            for (int j = 0; j < k_r; j++) begin
                q_cmd[j]   = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(2000, 0)) - 1000;
                q_ticks[j] = $urandom_range(12, 0);
                push_seg(1'b0, q_cmd[j], 0, q_ticks[j]);
            end
            check("rand_level", fifoLevel, k_r);
            check("rand_ready", segReady, (k_r < DEPTH));
            s_r = 0; cur_r = 0; rem_r = 0; act_m = 1'b0; und_m = 1'b0; fin = 1'b0;
            for (int c = 0; c < 300 && !fin; c++) begin
                e_r = ($urandom_range(3, 0) != 0);
                enable = e_r;
                done_p = 1'b0;
                if (act_m && e_r) begin
                    rem_r--;
                    if (rem_r == 0) begin
                        done_p = 1'b1;
                        act_m  = 1'b0;
                        if (s_r == k_r && q_cmd[cur_r] != 0) und_m = 1'b1;
                    end
                end
                if (!act_m && e_r && s_r < k_r) begin
                    cur_r = s_r;
                    s_r++;
                    act_m = 1'b1;
                    rem_r = (q_ticks[cur_r] == 0) ? 1 : q_ticks[cur_r];
                end
                exp_cmd = act_m ? q_cmd[cur_r] : 0;
                exp_jen = act_m ? e_r : 1'b0;
                exp_v   = {exp_cmd, exp_jen, act_m, done_p, und_m, LW'(k_r - s_r)};
                step();
                act_v = {jointFreqCmd, jointEnable, busy, segDone, underrun, fifoLevel};
                check($sformatf("rand_r%0d_c%0d", r, c), act_v, exp_v);
                if (!act_m && s_r == k_r) fin = 1'b1;
            end
            check("rand_idle", {busy, fifoLevel}, 0);
        end

        // Asynchronous reset in the middle of a segment
        enable = 1'b0;
        push_seg(1'b0, 77, 0, 50);
        enable = 1'b1;
        step(); step();
        check("rstmid_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_out", {busy, jointEnable, jointFreqCmd}, 0);
        check("rstmid_level", fifoLevel, 0);
        check("rstmid_ready", segReady, 1);
        step();
        rst_n = 1'b1;
        step(); step();
        check("rstmid_queue_lost", {busy, fifoLevel}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
